register_file: RTL and testbench

//   RISC-V RV32I integer register file (x0..x31) for the five-stage pipeline.
//   ID stage reads rs1/rs2 through two asynchronous read ports.
//   WB stage writes rd through one synchronous write port.
//   x0 is hardwired to zero; a same-cycle WB write is bypassed to the ID reads.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/regfile_read_port.sv | 20 ++
 rtl/register_file.sv | 32 +++
 tb/tb_register_file.sv | 92 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths and register-index types
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one async read port with x0 forcing and WB write-through bypass
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] array [2**ADDR_W],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);
  // Reset must also kill the bypass, since wr_data is live even while the array is held clear
  always_comb data = (!reset || idx == ADDR_W'(REG_ZERO)) ? '0
                   : (wr_en && wr_idx == idx)            ? wr_data
                   : array[idx];
endmodule

// File: rtl/register_file.sv
// register_file: RV32I x0..x31 with two async read ports and one sync write port
module register_file
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriterData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  logic [DATA_W-1:0] r_regs [2**ADDR_W];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    else if (RegWrite && WriteRegister != ADDR_W'(REG_ZERO))
      r_regs[WriteRegister] <= WriterData;
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .reset(reset), .idx(ReadRegister1), .array(r_regs), .wr_en(RegWrite),
    .wr_idx(WriteRegister), .wr_data(WriterData), .data(ReadData1)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .reset(reset), .idx(ReadRegister2), .array(r_regs), .wr_en(RegWrite),
    .wr_idx(WriteRegister), .wr_data(WriterData), .data(ReadData2)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset, write, x0, bypass, dual read and async reset
module tb_register_file;
  logic clk = 0;
  logic reset;
  logic RegWrite;
  logic [4:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriterData, ReadData1, ReadData2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  register_file dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriterData(WriterData),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    RegWrite = 1; WriteRegister = rd; WriterData = d;
    @(posedge clk);
    #1 RegWrite = 0;
  endtask
  initial begin
    reset = 0; RegWrite = 1; WriteRegister = 5'd3; WriterData = 32'h55;
    ReadRegister1 = 0; ReadRegister2 = 0;
    #2;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1 chk($sformatf("rst_rd1_x%0d", i), ReadData1, 32'h0);
      chk($sformatf("rst_rd2_x%0d", 31 - i), ReadData2, 32'h0);
    end
    ReadRegister1 = 5'd3;
    @(posedge clk); #1;
    chk("rst_write_ignored", ReadData1, 32'h0);
    @(negedge clk);
    reset = 1; RegWrite = 0;
    #1 chk("post_rst_x3", ReadData1, 32'h0);
    wr(5'd1, 32'h2);
    ReadRegister1 = 5'd1;
    #1 chk("basic_x1", ReadData1, 32'h2);
    wr(5'd0, 32'hDEADBEEF);
    ReadRegister1 = 0; ReadRegister2 = 0;
    #1 chk("x0_rd1", ReadData1, 32'h0);
    chk("x0_rd2", ReadData2, 32'h0);
    RegWrite = 1; WriteRegister = 0; WriterData = 32'hDEADBEEF;
    #1 chk("x0_held_rd1", ReadData1, 32'h0);
    chk("x0_held_rd2", ReadData2, 32'h0);
    @(posedge clk); #1 RegWrite = 0;
    wr(5'd5, 32'h11);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    #1 chk("x5_init", ReadData2, 32'h11);
    @(negedge clk);
    RegWrite = 1; WriteRegister = 5'd5; WriterData = 32'h22;
    #1 chk("bypass_rd2", ReadData2, 32'h22);
    chk("bypass_rd1_same", ReadData1, 32'h22);
    @(posedge clk); #1 RegWrite = 0;
    #1 chk("bypass_committed", ReadData2, 32'h22);
    wr(5'd31, 32'hFFFFFFFF);
    wr(5'd30, 32'h80000000);
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd30;
    #1 chk("dual_x31", ReadData1, 32'hFFFFFFFF);
    chk("dual_x30", ReadData2, 32'h80000000);
    @(negedge clk);
    RegWrite = 0; WriteRegister = 5'd31; WriterData = 32'h0;
    #1 chk("wdis_pre_x31", ReadData1, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("wdis_post_x31", ReadData1, 32'hFFFFFFFF);
    @(posedge clk);
    #3 reset = 0;
    #1 chk("async_x31", ReadData1, 32'h0);
    chk("async_x30", ReadData2, 32'h0);
    RegWrite = 1; WriteRegister = 5'd7; WriterData = 32'h77; ReadRegister1 = 5'd7;
    #1 chk("rst_bypass_off", ReadData1, 32'h0);
    @(posedge clk); #2;
    RegWrite = 0; reset = 1;
    #1 chk("rst_write_x7", ReadData1, 32'h0);
    ReadRegister2 = 5'd1;
    #1 chk("rst_cleared_x1", ReadData2, 32'h0);
    wr(5'd9, 32'h99);
    ReadRegister1 = 5'd9;
    #1 chk("first_write_after_rst", ReadData1, 32'h99);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
